switch_input_conditioner: RTL



---
 rtl/switch_input_conditioner.sv | 95 +++++++++
 1 files changed

// File: rtl/switch_input_conditioner.sv
// Slide-switch front end: per-bit two-flop synchronizer and debounce, one-cycle
// rise/fall pulses, and a sticky change mask cleared by software acknowledge.

module switch_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_nxt,
  output logic o_fall_nxt
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1, r_s2, r_clean, r_rise, r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff, w_take;

  assign w_diff     = r_s2 ^ r_clean;
  assign w_take     = w_diff && (r_cnt == CNT_MAX);
  assign o_rise_nxt = w_take &  r_s2;
  assign o_fall_nxt = w_take & ~r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1   <= i_sw;
      r_s2   <= r_s1;
      r_rise <= o_rise_nxt;
      r_fall <= o_fall_nxt;
      // any return to agreement before the count completes discards the run
      if (!w_diff || w_take) r_cnt <= '0;
      else                   r_cnt <= r_cnt + CNT_W'(1);
      if (w_take) r_clean <= r_s2;
    end
  end

  assign o_clean = r_clean;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

module switch_input_conditioner #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             change_ack,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] change_mask,
  output logic             any_change
);
  logic [WIDTH-1:0] w_rise_nxt, w_fall_nxt;
  logic [WIDTH-1:0] r_mask;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    switch_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_sw      (sw_in[i]),
      .o_clean   (sw_clean[i]),
      .o_rise    (sw_rise[i]),
      .o_fall    (sw_fall[i]),
      .o_rise_nxt(w_rise_nxt[i]),
      .o_fall_nxt(w_fall_nxt[i])
    );
  end

  // a new event on a bit outranks an acknowledge arriving in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mask <= '0;
    else        r_mask <= (change_ack ? '0 : r_mask) | w_rise_nxt | w_fall_nxt;
  end

  assign change_mask = r_mask;
  assign any_change  = |r_mask;
endmodule
